// File: rtl/ex_div_arbiter_pkg.sv
// Shared definitions for the dual-line EX divider: op bit indices, FSM
// encoding and the context latched at grant time.
package ex_div_arbiter_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 5;

  localparam int DIV_OP_SIGNED = 0;
  localparam int DIV_OP_MOD    = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } div_state_e;

  // Everything needed at the end of the iteration to finish the result.
  typedef struct packed {
    logic owner;     // 0: line1, 1: line2
    logic mod_op;
    logic neg_q;
    logic neg_r;
    logic div_zero;
  } div_ctx_t;

  // Line1 is older and always wins when both are eligible.
  function automatic logic pick_line2(input logic [1:0] elig);
    return ~elig[0] & elig[1];
  endfunction

endpackage

// File: rtl/ex_div_arbiter_if.sv
// Request/result bundle between the two EX lines and the shared divider.
interface ex_div_arbiter_if #(
  parameter int DATA_W = 32
);

  logic              excep_flush_i;

  logic              line1_req_i;
  logic [1:0]        line1_op_i;
  logic [DATA_W-1:0] line1_src1_i;
  logic [DATA_W-1:0] line1_src2_i;
  logic              line1_ack_i;
  logic              line1_done_o;
  logic [DATA_W-1:0] line1_result_o;

  logic              line2_req_i;
  logic [1:0]        line2_op_i;
  logic [DATA_W-1:0] line2_src1_i;
  logic [DATA_W-1:0] line2_src2_i;
  logic              line2_ack_i;
  logic              line2_done_o;
  logic [DATA_W-1:0] line2_result_o;

  logic              busy_o;

  modport master (
    output excep_flush_i,
    output line1_req_i, line1_op_i, line1_src1_i, line1_src2_i, line1_ack_i,
    output line2_req_i, line2_op_i, line2_src1_i, line2_src2_i, line2_ack_i,
    input  line1_done_o, line1_result_o,
    input  line2_done_o, line2_result_o,
    input  busy_o
  );

  modport slave (
    input  excep_flush_i,
    input  line1_req_i, line1_op_i, line1_src1_i, line1_src2_i, line1_ack_i,
    input  line2_req_i, line2_op_i, line2_src1_i, line2_src2_i, line2_ack_i,
    output line1_done_o, line1_result_o,
    output line2_done_o, line2_result_o,
    output busy_o
  );

endinterface

// File: rtl/ex_div_arbiter_div_iter_core.sv
// Unsigned restoring divider, one quotient bit per step. Sign handling and
// arbitration live in the parent; this block only sees magnitudes.
module ex_div_arbiter_div_iter_core #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              last,
  output logic [DATA_W-1:0] quo_next,
  output logic [DATA_W-1:0] rem_next
);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   trial;

  // rem < dvs always holds, so the trial difference never needs more than DATA_W+1 bits.
  assign trial = {rem, quo[DATA_W-1]} - {1'b0, dvs};
  assign last  = (cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    quo_next = {quo[DATA_W-2:0], 1'b0};
    rem_next = {rem[DATA_W-2:0], quo[DATA_W-1]};
    if (!trial[DATA_W]) begin
      quo_next = {quo[DATA_W-2:0], 1'b1};
      rem_next = trial[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: rtl/ex_div_arbiter.sv
// Shared iterative divider for the dual-issue EX stage: grants line1/line2,
// runs the core, applies sign fix-up and holds each line's result until ack.
//
// state   | meaning
// ST_IDLE | no division running; a request may be granted this cycle
// ST_BUSY | core iterating for ctx_q.owner, one bit per cycle
module ex_div_arbiter
  import ex_div_arbiter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  ex_div_arbiter_if.slave bus
);

  div_state_e        state_q;
  div_state_e        state_d;

  logic              flush;
  logic [1:0]        req;
  logic [1:0]        ack;
  logic [1:0]        elig;
  logic [1:0]        res_vld;
  logic [DATA_W-1:0] res [2];

  logic              busy;
  logic              grant_vld;
  logic              grant_line;
  logic              step;
  logic              finish;

  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  div_ctx_t          ctx_q;
  logic              core_last;
  logic [DATA_W-1:0] core_quo;
  logic [DATA_W-1:0] core_rem;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic [DATA_W-1:0] res_val;

  assign flush = bus.excep_flush_i;
  assign req   = {bus.line2_req_i, bus.line1_req_i};
  assign ack   = {bus.line2_ack_i, bus.line1_ack_i};
  // A line holding an unconsumed result cannot be regranted.
  assign elig  = req & ~res_vld & {2{~flush}};

  assign grant_line = pick_line2(elig);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (|elig)     state_d = ST_BUSY;
        ST_BUSY: if (core_last) state_d = ST_IDLE;
        default:                state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    grant_vld = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: grant_vld = |elig;
      ST_BUSY: begin
        busy   = 1'b1;
        step   = ~flush;
        finish = ~flush & core_last;
      end
      default: ;
    endcase
  end

  assign sel_op = grant_line ? bus.line2_op_i   : bus.line1_op_i;
  assign sel_a  = grant_line ? bus.line2_src1_i : bus.line1_src1_i;
  assign sel_b  = grant_line ? bus.line2_src2_i : bus.line1_src2_i;

  assign a_neg = sel_op[DIV_OP_SIGNED] & sel_a[DATA_W-1];
  assign b_neg = sel_op[DIV_OP_SIGNED] & sel_b[DATA_W-1];
  assign a_mag = a_neg ? -sel_a : sel_a;
  assign b_mag = b_neg ? -sel_b : sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_q <= '0;
    end else if (grant_vld) begin
      ctx_q.owner    <= grant_line;
      ctx_q.mod_op   <= sel_op[DIV_OP_MOD];
      ctx_q.neg_q    <= a_neg ^ b_neg;
      ctx_q.neg_r    <= a_neg;
      ctx_q.div_zero <= (sel_b == '0);
    end
  end

  ex_div_arbiter_div_iter_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .start    (grant_vld),
    .step     (step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .last     (core_last),
    .quo_next (core_quo),
    .rem_next (core_rem)
  );

  // With a zero divisor the core already leaves |dividend| as remainder, so
  // the dividend's sign restores the original value; only the quotient is forced.
  assign q_fix   = ctx_q.neg_q ? -core_quo : core_quo;
  assign r_fix   = ctx_q.neg_r ? -core_rem : core_rem;
  assign res_val = ctx_q.mod_op   ? r_fix :
                   ctx_q.div_zero ? '1    : q_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= '0;
      res[0]  <= '0;
      res[1]  <= '0;
    end else if (flush) begin
      res_vld <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (finish && (ctx_q.owner == 1'(i))) begin
          res_vld[i] <= 1'b1;
          res[i]     <= res_val;
        end else if (ack[i]) begin
          res_vld[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.busy_o         = busy;
  assign bus.line1_done_o   = res_vld[0];
  assign bus.line2_done_o   = res_vld[1];
  assign bus.line1_result_o = res[0];
  assign bus.line2_result_o = res[1];

endmodule

// File: tb/tb_ex_div_arbiter.sv
// Bench for ex_div_arbiter: directed latency/value checks plus randomized
// two-line traffic compared every cycle against a transaction-level model.
module tb_ex_div_arbiter;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  ex_div_arbiter_if #(.DATA_W(32)) bus ();

  ex_div_arbiter #(.DATA_W(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain language arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Model: a granted op occupies the divider for 32 cycles after its grant edge,
  // then its result is held for the owning line until that line acks.
  bit          m_busy = 0;
  int          m_left = 0;
  int          m_owner = 0;
  logic [31:0] m_pend = '0;
  logic [1:0]  m_vld = '0;
  logic [31:0] m_res [2];
  logic [1:0]  m_set;
  logic [1:0]  m_req;
  logic [1:0]  m_ack;

  always @(posedge clk) begin
    m_req = {bus.line2_req_i, bus.line1_req_i};
    m_ack = {bus.line2_ack_i, bus.line1_ack_i};
    m_set = '0;
    if (rst) begin
      m_busy = 0; m_left = 0; m_vld = '0; m_res[0] = '0; m_res[1] = '0;
    end else if (bus.excep_flush_i) begin
      m_busy = 0; m_left = 0; m_vld = '0;
    end else begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_vld[m_owner] = 1'b1;
          m_res[m_owner] = m_pend;
          m_set[m_owner] = 1'b1;
        end
      end else if (m_req[0] && !m_vld[0]) begin
        m_busy = 1; m_left = 32; m_owner = 0;
        m_pend = ref_div(bus.line1_op_i, bus.line1_src1_i, bus.line1_src2_i);
      end else if (m_req[1] && !m_vld[1]) begin
        m_busy = 1; m_left = 32; m_owner = 1;
        m_pend = ref_div(bus.line2_op_i, bus.line2_src1_i, bus.line2_src2_i);
      end
      for (int i = 0; i < 2; i++)
        if (m_ack[i] && !m_set[i]) m_vld[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",  {31'd0, bus.busy_o},       {31'd0, m_busy});
      chk("cyc_done1", {31'd0, bus.line1_done_o}, {31'd0, m_vld[0]});
      chk("cyc_done2", {31'd0, bus.line2_done_o}, {31'd0, m_vld[1]});
      if (m_vld[0]) chk("cyc_res1", bus.line1_result_o, m_res[0]);
      if (m_vld[1]) chk("cyc_res2", bus.line2_result_o, m_res[1]);
    end
  end

  task automatic set_line(input int line, input logic req, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    if (line == 1) begin
      bus.line1_req_i = req; bus.line1_op_i = op; bus.line1_src1_i = a; bus.line1_src2_i = b;
    end else begin
      bus.line2_req_i = req; bus.line2_op_i = op; bus.line2_src1_i = a; bus.line2_src2_i = b;
    end
  endtask

  function automatic logic get_done(input int line);
    return (line == 1) ? bus.line1_done_o : bus.line2_done_o;
  endfunction

  function automatic logic [31:0] get_res(input int line);
    return (line == 1) ? bus.line1_result_o : bus.line2_result_o;
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic run_single(input int line, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input string name);
    int n;
    bit got;
    n = 0; got = 0;
    set_line(line, 1'b1, op, a, b);
    while (!got && n < 40) begin
      @(negedge clk); n++;
      got = get_done(line);
    end
    chk({name, "_lat"}, 32'(n), 32'd33);
    chk({name, "_val"}, get_res(line), exp);
    chk({name, "_other"}, {31'd0, get_done(3 - line)}, 32'd0);
    if (line == 1) bus.line1_ack_i = 1'b1; else bus.line2_ack_i = 1'b1;
    @(negedge clk);
    bus.line1_ack_i = 1'b0; bus.line2_ack_i = 1'b0;
    set_line(line, 1'b0, 2'b00, 32'd0, 32'd0);
    chk({name, "_clr"}, {31'd0, get_done(line)}, 32'd0);
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n, n1, n2, flush_at;
    bit ok, hold_ok, flushed, r1, r2;

    rst = 1'b1;
    bus.excep_flush_i = 1'b0;
    bus.line1_ack_i = 1'b0; bus.line2_ack_i = 1'b0;
    set_line(1, 1'b0, 2'b00, 32'd0, 32'd0);
    set_line(2, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done1", {31'd0, bus.line1_done_o}, 32'd0);
    chk("rst_done2", {31'd0, bus.line2_done_o}, 32'd0);
    chk("rst_res1",  bus.line1_result_o, 32'd0);
    chk("rst_res2",  bus.line2_result_o, 32'd0);
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);

    run_single(1, 2'b00, 32'd100, 32'd7, 32'd14, "t1_udiv");
    run_single(2, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "t2_smod");
    run_single(2, 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "t2_sdiv");
    run_single(1, 2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "t4_dz_q");
    run_single(1, 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, "t4_dz_r");
    run_single(2, 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "t4_dz_sr");
    run_single(1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "t4_ovf");

    // Both lines at once: line1 first, line2 right after, both acked together.
    set_line(1, 1'b1, 2'b00, 32'd20, 32'd3);
    set_line(2, 1'b1, 2'b10, 32'd20, 32'd3);
    n = 0; n1 = 0; n2 = 0;
    while (n < 80 && n2 == 0) begin
      @(negedge clk); n++;
      if (n1 == 0 && bus.line1_done_o) n1 = n;
      if (n2 == 0 && bus.line2_done_o) n2 = n;
    end
    chk("t3_l1_lat", 32'(n1), 32'd33);
    chk("t3_l2_lat", 32'(n2), 32'd66);
    chk("t3_l1_held", {31'd0, bus.line1_done_o}, 32'd1);
    chk("t3_l1_val", bus.line1_result_o, 32'd6);
    chk("t3_l2_val", bus.line2_result_o, 32'd2);
    bus.line1_ack_i = 1'b1; bus.line2_ack_i = 1'b1;
    @(negedge clk);
    bus.line1_ack_i = 1'b0; bus.line2_ack_i = 1'b0;
    set_line(1, 1'b0, 2'b00, 32'd0, 32'd0);
    set_line(2, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("t3_clr", {30'd0, bus.line2_done_o, bus.line1_done_o}, 32'd0);

    // Flush ten cycles into an op, then a fresh request right after.
    set_line(1, 1'b1, 2'b00, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    bus.excep_flush_i = 1'b1;
    @(negedge clk);
    bus.excep_flush_i = 1'b0;
    chk("t5_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("t5_done", {31'd0, bus.line1_done_o}, 32'd0);
    run_single(1, 2'b00, 32'd500, 32'd7, 32'd71, "t5_new");

    // Held request with an unconsumed result must not regrant.
    set_line(1, 1'b1, 2'b00, 32'd9, 32'd2);
    n = 0;
    while (!bus.line1_done_o && n < 40) begin @(negedge clk); n++; end
    chk("t6_lat", 32'(n), 32'd33);
    hold_ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (bus.busy_o || !bus.line1_done_o || bus.line1_result_o != 32'd4) hold_ok = 0;
    end
    chk("t6_hold", {31'd0, hold_ok}, 32'd1);
    bus.line1_ack_i = 1'b1;
    @(negedge clk);
    bus.line1_ack_i = 1'b0;
    set_line(1, 1'b0, 2'b00, 32'd0, 32'd0);

    // Reset in the middle of an operation.
    set_line(1, 1'b1, 2'b00, 32'h1000, 32'd3);
    set_line(2, 1'b1, 2'b00, 32'h55, 32'd5);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("t6_rst_done", {30'd0, bus.line2_done_o, bus.line1_done_o}, 32'd0);
    chk("t6_rst_res1", bus.line1_result_o, 32'd0);
    chk("t6_rst_res2", bus.line2_result_o, 32'd0);
    set_line(1, 1'b0, 2'b00, 32'd0, 32'd0);
    set_line(2, 1'b0, 2'b00, 32'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Random two-line traffic; both lines ack together once all their ops are done.
    for (int g = 0; g < 200; g++) begin
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      set_line(1, r1, 2'($urandom_range(0, 3)), pick_opnd(), pick_opnd());
      set_line(2, r2, 2'($urandom_range(0, 3)), pick_opnd(), pick_opnd());
      flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 70) : 0;
      flushed = 0; ok = 0; n = 0;
      while (n < 100) begin
        ok = (!r1 || bus.line1_done_o) && (!r2 || bus.line2_done_o);
        if (ok) break;
        if (flush_at != 0 && flush_at == n) begin
          bus.excep_flush_i = 1'b1;
          @(negedge clk);
          bus.excep_flush_i = 1'b0;
          bus.line1_req_i = 1'b0; bus.line2_req_i = 1'b0;
          flushed = 1;
          break;
        end
        @(negedge clk); n++;
      end
      if (!flushed) begin
        chk("rnd_wait", {31'd0, ok}, 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.line1_ack_i = 1'b1; bus.line2_ack_i = 1'b1;
        @(negedge clk);
        bus.line1_ack_i = 1'b0; bus.line2_ack_i = 1'b0;
        bus.line1_req_i = 1'b0; bus.line2_req_i = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
